// File: rtl/backend_pkg.sv
// Shared backend definitions for the register-read stage.
// Holds the lane count, writeback port count, preg/operand types, the
// per-lane stage record, and the operand select helper. The helper is
// used only when RR_BYPASS_EN is defined.
package backend_pkg;

  localparam int NUM_FUS   = 4;
  localparam int NUM_WB    = NUM_FUS - 1;  // the last FU writes no destination
  localparam int NUM_PREGS = 64;
  localparam int PREG_W    = $clog2(NUM_PREGS);
  localparam int UOP_W     = 48;
  localparam int DATA_W    = 32;

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [DATA_W-1:0] data_t;

  // Contents of one lane's stage register, as presented to the FU.
  typedef struct packed {
    logic [UOP_W-1:0] uop;
    data_t            src1_val;
    data_t            src2_val;
  } rr_uop_t;

  // Operand select for one source.
  // Preg 0 always reads as zero and is never bypassed.
  // Otherwise the lowest-numbered writeback port that targets src wins.
  // With no match, base is returned (PRF data or the currently held value).
  function automatic data_t operand_sel(
    input preg_t                   src,
    input data_t                   base,
    input logic  [NUM_WB-1:0]      wb_valid,
    input preg_t [NUM_WB-1:0]      wb_dst,
    input data_t [NUM_WB-1:0]      wb_val
  );
    data_t result;
    logic  hit;
    result = base;
    hit    = 1'b0;
    if (src == '0) begin
      result = '0;
    end else begin
      for (int j = 0; j < NUM_WB; j++) begin
        if (!hit && wb_valid[j] && (wb_dst[j] == src)) begin
          result = wb_val[j];
          hit    = 1'b1;
        end
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_lane.sv
// One register-read lane.
// The lane implements the issue/execute handshake, the stage register and
// the operand mux. The ready path is purely combinational (no skid buffer),
// so a stalled FU back-pressures issue on the same cycle.
// Build option RR_BYPASS_EN: when defined, writeback data is forwarded both
// at capture and into a held (stalled) uop. When undefined, operands come
// from the PRF only and the wb_* inputs are ignored.
module rr_lane
  import backend_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_en,
  input  logic                    iss_valid,
  output logic                    iss_ready,
  input  preg_t                   iss_src1,
  input  preg_t                   iss_src2,
  input  logic  [UOP_W-1:0]       iss_uop,
  input  data_t                   prf_val1,
  input  data_t                   prf_val2,
  input  logic  [NUM_WB-1:0]      wb_valid,
  input  preg_t [NUM_WB-1:0]      wb_dst,
  input  data_t [NUM_WB-1:0]      wb_val,
  output logic                    ex_valid,
  input  logic                    ex_ready,
  output logic  [UOP_W-1:0]       ex_uop,
  output data_t                   ex_src1_val,
  output data_t                   ex_src2_val
);

  rr_uop_t stage_q;
  logic    valid_q;
  logic    accept;
  data_t   cap1;
  data_t   cap2;

  // The lane can take a new uop when it is empty or its current uop
  // leaves this cycle. A flush blocks issue for the whole cycle.
  assign iss_ready = !flush_en && (!valid_q || ex_ready);
  assign accept    = iss_valid && iss_ready;

`ifdef RR_BYPASS_EN
  preg_t src1_q;
  preg_t src2_q;
  data_t held1;
  data_t held2;

  // Capture values come from the writeback bus when it hits, else from the PRF.
  // Held values are refreshed from the writeback bus while the uop waits.
  // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
  always_comb begin
    cap1  = operand_sel(iss_src1, prf_val1, wb_valid, wb_dst, wb_val);
    cap2  = operand_sel(iss_src2, prf_val2, wb_valid, wb_dst, wb_val);
    held1 = operand_sel(src1_q, stage_q.src1_val, wb_valid, wb_dst, wb_val);
    held2 = operand_sel(src2_q, stage_q.src2_val, wb_valid, wb_dst, wb_val);
  end

  // Remember the source pregs of the held uop so late writebacks can find it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      src1_q <= '0;
      src2_q <= '0;
    end else if (accept) begin
      src1_q <= iss_src1;
      src2_q <= iss_src2;
    end
  end
`else
  // Capture values come from the PRF only. Preg 0 is forced to zero.
  always_comb begin
    cap1 = (iss_src1 == '0) ? '0 : prf_val1;
    cap2 = (iss_src2 == '0) ? '0 : prf_val2;
  end

  // The writeback bus is intentionally unused in this build.
  logic unused_wb;
  assign unused_wb = ^{wb_valid, wb_dst, wb_val};
`endif

  // Stage register. Priority is reset, then flush, then capture.
  // Otherwise the lane drains when the FU accepts, or holds while stalled.
  // NOTE: non-blocking assignments here so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      // NOTE: the data register is reset too, so the FU-facing outputs read zero after reset.
      stage_q <= '0;
    end else if (flush_en) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      stage_q <= '{uop: iss_uop, src1_val: cap1, src2_val: cap2};
    end else begin
      if (ex_ready) begin
        valid_q <= 1'b0;
      end
`ifdef RR_BYPASS_EN
      if (valid_q) begin
        stage_q.src1_val <= held1;
        stage_q.src2_val <= held2;
      end
`endif
    end
  end

  assign ex_valid    = valid_q;
  assign ex_uop      = stage_q.uop;
  assign ex_src1_val = stage_q.src1_val;
  assign ex_src2_val = stage_q.src2_val;

endmodule

// File: rtl/reg_read_stage.sv
// Register-read pipeline stage between issue and execute. There is one
// independent rr_lane per functional unit. This level only slices the
// flat lane buses and forwards the source indices to the PRF read ports.
// Build option RR_BYPASS_EN enables writeback forwarding inside the lanes.
module reg_read_stage
  import backend_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush_en,
  input  logic [NUM_FUS-1:0]          iss_valid,
  output logic [NUM_FUS-1:0]          iss_ready,
  input  logic [NUM_FUS*PREG_W-1:0]   iss_src1,
  input  logic [NUM_FUS*PREG_W-1:0]   iss_src2,
  input  logic [NUM_FUS*UOP_W-1:0]    iss_uop,
  output logic [NUM_FUS*PREG_W-1:0]   prf_src1,
  output logic [NUM_FUS*PREG_W-1:0]   prf_src2,
  input  logic [NUM_FUS*DATA_W-1:0]   prf_val1,
  input  logic [NUM_FUS*DATA_W-1:0]   prf_val2,
  input  logic [NUM_WB-1:0]           wb_valid,
  input  logic [NUM_WB*PREG_W-1:0]    wb_dst,
  input  logic [NUM_WB*DATA_W-1:0]    wb_val,
  output logic [NUM_FUS-1:0]          ex_valid,
  input  logic [NUM_FUS-1:0]          ex_ready,
  output logic [NUM_FUS*UOP_W-1:0]    ex_uop,
  output logic [NUM_FUS*DATA_W-1:0]   ex_src1_val,
  output logic [NUM_FUS*DATA_W-1:0]   ex_src2_val
);

  // The PRF is read with the issued indices directly; its data returns in the same cycle.
  assign prf_src1 = iss_src1;
  assign prf_src2 = iss_src2;

  // Every lane sees the same writeback bus. These views share the flat bus bit layout.
  preg_t [NUM_WB-1:0] wb_dst_arr;
  data_t [NUM_WB-1:0] wb_val_arr;
  assign wb_dst_arr = wb_dst;
  assign wb_val_arr = wb_val;

  for (genvar i = 0; i < NUM_FUS; i++) begin : g_lane
    rr_lane u_lane (
      .clk         (clk),
      .rst         (rst),
      .flush_en    (flush_en),
      .iss_valid   (iss_valid[i]),
      .iss_ready   (iss_ready[i]),
      .iss_src1    (iss_src1[i*PREG_W +: PREG_W]),
      .iss_src2    (iss_src2[i*PREG_W +: PREG_W]),
      .iss_uop     (iss_uop[i*UOP_W +: UOP_W]),
      .prf_val1    (prf_val1[i*DATA_W +: DATA_W]),
      .prf_val2    (prf_val2[i*DATA_W +: DATA_W]),
      .wb_valid    (wb_valid),
      .wb_dst      (wb_dst_arr),
      .wb_val      (wb_val_arr),
      .ex_valid    (ex_valid[i]),
      .ex_ready    (ex_ready[i]),
      .ex_uop      (ex_uop[i*UOP_W +: UOP_W]),
      .ex_src1_val (ex_src1_val[i*DATA_W +: DATA_W]),
      .ex_src2_val (ex_src2_val[i*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_reg_read_stage.sv
// Self-checking bench for reg_read_stage.
// The bench owns a behavioural PRF and a per-lane reference model of the
// stage. It runs directed vectors and sequences, then randomized traffic.
module tb_reg_read_stage;
  import backend_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      flush_en;
  logic [NUM_FUS-1:0]        iss_valid, iss_ready, ex_valid, ex_ready;
  logic [NUM_FUS*PREG_W-1:0] iss_src1, iss_src2, prf_src1, prf_src2;
  logic [NUM_FUS*UOP_W-1:0]  iss_uop, ex_uop;
  logic [NUM_FUS*32-1:0]     prf_val1, prf_val2, ex_src1_val, ex_src2_val;
  logic [NUM_WB-1:0]         wb_valid;
  logic [NUM_WB*PREG_W-1:0]  wb_dst;
  logic [NUM_WB*32-1:0]      wb_val;

  always #5 clk = ~clk;

  reg_read_stage dut (
    .clk(clk), .rst(rst), .flush_en(flush_en),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_src1(iss_src1), .iss_src2(iss_src2), .iss_uop(iss_uop),
    .prf_src1(prf_src1), .prf_src2(prf_src2),
    .prf_val1(prf_val1), .prf_val2(prf_val2),
    .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_val(wb_val),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_uop(ex_uop),
    .ex_src1_val(ex_src1_val), .ex_src2_val(ex_src2_val)
  );

  // Behavioural PRF: combinational read, written after each posedge.
  data_t prf [NUM_PREGS];
  always_comb begin
    prf_val1 = '0;
    prf_val2 = '0;
    for (int i = 0; i < NUM_FUS; i++) begin
      prf_val1[i*32 +: 32] = prf[prf_src1[i*PREG_W +: PREG_W]];
      prf_val2[i*32 +: 32] = prf[prf_src2[i*PREG_W +: PREG_W]];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model state per lane.
  logic             m_valid [NUM_FUS];
  logic [UOP_W-1:0] m_uop   [NUM_FUS];
  data_t            m_v1    [NUM_FUS];
  data_t            m_v2    [NUM_FUS];
  preg_t            m_s1    [NUM_FUS];
  preg_t            m_s2    [NUM_FUS];

  // Operand value seen by the execute side for source src, given a fallback value.
  function automatic data_t model_operand(input preg_t src, input data_t fallback);
    if (src == 0) return 32'h0;
`ifdef RR_BYPASS_EN
    for (int j = 0; j < NUM_WB; j++)
      if (wb_valid[j] && wb_dst[j*PREG_W +: PREG_W] == src) return wb_val[j*32 +: 32];
`endif
    return fallback;
  endfunction

  // One clock: check the combinational outputs, advance the model, then check registered outputs.
  task automatic cycle();
    logic             n_valid [NUM_FUS];
    logic [UOP_W-1:0] n_uop   [NUM_FUS];
    data_t            n_v1    [NUM_FUS];
    data_t            n_v2    [NUM_FUS];
    preg_t            n_s1    [NUM_FUS];
    preg_t            n_s2    [NUM_FUS];
    logic [NUM_WB-1:0]        wv;
    logic [NUM_WB*PREG_W-1:0] wd;
    logic [NUM_WB*32-1:0]     wval;
    logic rdy;
    #1;
    check("prf_src1", 64'(prf_src1), 64'(iss_src1));
    check("prf_src2", 64'(prf_src2), 64'(iss_src2));
    for (int i = 0; i < NUM_FUS; i++) begin
      rdy = !flush_en && (!m_valid[i] || ex_ready[i]);
      check($sformatf("iss_ready[%0d]", i), 64'(iss_ready[i]), 64'(rdy));
      n_valid[i] = m_valid[i]; n_uop[i] = m_uop[i];
      n_v1[i] = m_v1[i]; n_v2[i] = m_v2[i]; n_s1[i] = m_s1[i]; n_s2[i] = m_s2[i];
      if (!rst) begin
        n_valid[i] = 1'b0; n_uop[i] = '0; n_v1[i] = '0; n_v2[i] = '0; n_s1[i] = '0; n_s2[i] = '0;
      end else if (flush_en) begin
        n_valid[i] = 1'b0;
      end else if (iss_valid[i] && rdy) begin
        n_valid[i] = 1'b1;
        n_uop[i]   = iss_uop[i*UOP_W +: UOP_W];
        n_s1[i]    = iss_src1[i*PREG_W +: PREG_W];
        n_s2[i]    = iss_src2[i*PREG_W +: PREG_W];
        n_v1[i]    = model_operand(n_s1[i], prf[n_s1[i]]);
        n_v2[i]    = model_operand(n_s2[i], prf[n_s2[i]]);
      end else begin
        if (m_valid[i] && ex_ready[i]) n_valid[i] = 1'b0;
`ifdef RR_BYPASS_EN
        if (m_valid[i]) begin
          n_v1[i] = model_operand(m_s1[i], m_v1[i]);
          n_v2[i] = model_operand(m_s2[i], m_v2[i]);
        end
`endif
      end
    end
    wv = wb_valid; wd = wb_dst; wval = wb_val;
    @(posedge clk);
    #1;
    for (int j = NUM_WB - 1; j >= 0; j--)
      if (wv[j] && wd[j*PREG_W +: PREG_W] != 0) prf[wd[j*PREG_W +: PREG_W]] = wval[j*32 +: 32];
    for (int i = 0; i < NUM_FUS; i++) begin
      m_valid[i] = n_valid[i]; m_uop[i] = n_uop[i];
      m_v1[i] = n_v1[i]; m_v2[i] = n_v2[i]; m_s1[i] = n_s1[i]; m_s2[i] = n_s2[i];
      check($sformatf("ex_valid[%0d]", i), 64'(ex_valid[i]), 64'(m_valid[i]));
      if (m_valid[i]) begin
        check($sformatf("ex_uop[%0d]", i), 64'(ex_uop[i*UOP_W +: UOP_W]), 64'(m_uop[i]));
        check($sformatf("ex_src1_val[%0d]", i), 64'(ex_src1_val[i*32 +: 32]), 64'(m_v1[i]));
        check($sformatf("ex_src2_val[%0d]", i), 64'(ex_src2_val[i*32 +: 32]), 64'(m_v2[i]));
      end
    end
  endtask

  task automatic idle();
    iss_valid = '0; flush_en = 1'b0; ex_ready = '1; wb_valid = '0;
    iss_src1 = '0; iss_src2 = '0; iss_uop = '0; wb_dst = '0; wb_val = '0;
  endtask

  task automatic issue(input int lane, input preg_t s1, input preg_t s2, input logic [UOP_W-1:0] uop);
    iss_valid[lane] = 1'b1;
    iss_src1[lane*PREG_W +: PREG_W] = s1;
    iss_src2[lane*PREG_W +: PREG_W] = s2;
    iss_uop[lane*UOP_W +: UOP_W]    = uop;
  endtask

  task automatic set_wb(input int j, input preg_t dst, input data_t val);
    wb_valid[j] = 1'b1;
    wb_dst[j*PREG_W +: PREG_W] = dst;
    wb_val[j*32 +: 32] = val;
  endtask

  typedef struct {
    int               lane;
    preg_t            s1;
    preg_t            s2;
    logic [UOP_W-1:0] uop;
    data_t            e1;
    data_t            e2;
  } vec_t;

  vec_t vecs [4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [UOP_W-1:0] held_uop;
    for (int p = 0; p < NUM_PREGS; p++) prf[p] = (p == 0) ? 32'h0 : 32'h1000_0000 + 32'(p * 3);
    prf[5] = 32'h0000_1234;
    prf[7] = 32'h0000_BEEF;
    prf[9] = 32'h0000_1111;
    prf[12] = 32'h0000_0003;
    for (int i = 0; i < NUM_FUS; i++) begin
      m_valid[i] = 1'b0; m_uop[i] = '0; m_v1[i] = '0; m_v2[i] = '0; m_s1[i] = '0; m_s2[i] = '0;
    end

    // Test 1: reset held for two cycles with every lane issuing.
    idle();
    rst = 1'b0;
    iss_valid = '1;
    iss_uop = {NUM_FUS{48'hDEAD_BEEF_CAFE}};
    iss_src1 = {NUM_FUS{6'd5}};
    @(posedge clk);
    #1;
    cycle();
    check("reset ex_valid", 64'(ex_valid), 64'h0);
    check("reset ex_uop", 64'(|ex_uop), 64'h0);
    check("reset ex_src1_val", 64'(|ex_src1_val), 64'h0);
    check("reset ex_src2_val", 64'(|ex_src2_val), 64'h0);
    rst = 1'b1;
    idle();
    #1;
    check("ready after reset", 64'(iss_ready), 64'hF);
    cycle();

    // Test 2: table of basic reads, one lane at a time.
    vecs[0] = '{0, 6'd5, 6'd7, 48'h0000_0000_0A01, 32'h1234, 32'hBEEF};
    vecs[1] = '{1, 6'd7, 6'd5, 48'h0000_0000_0B02, 32'hBEEF, 32'h1234};
    vecs[2] = '{2, 6'd0, 6'd5, 48'h0000_0000_0C03, 32'h0,    32'h1234};
    vecs[3] = '{3, 6'd7, 6'd0, 48'h0000_0000_0D04, 32'hBEEF, 32'h0};
    for (int v = 0; v < 4; v++) begin
      idle();
      issue(vecs[v].lane, vecs[v].s1, vecs[v].s2, vecs[v].uop);
      cycle();
      check($sformatf("vec%0d valid", v), 64'(ex_valid[vecs[v].lane]), 64'h1);
      check($sformatf("vec%0d uop", v), 64'(ex_uop[vecs[v].lane*UOP_W +: UOP_W]), 64'(vecs[v].uop));
      check($sformatf("vec%0d src1", v), 64'(ex_src1_val[vecs[v].lane*32 +: 32]), 64'(vecs[v].e1));
      check($sformatf("vec%0d src2", v), 64'(ex_src2_val[vecs[v].lane*32 +: 32]), 64'(vecs[v].e2));
      idle();
      cycle();
    end

    // Test 3: same-cycle writeback of the source preg.
    idle();
    issue(1, 6'd9, 6'd7, 48'h0000_0000_3333);
    set_wb(0, 6'd9, 32'h0000_A5A5);
    cycle();
`ifdef RR_BYPASS_EN
    check("same-cycle bypass", 64'(ex_src1_val[32 +: 32]), 64'h0000_A5A5);
`else
    check("no bypass old value", 64'(ex_src1_val[32 +: 32]), 64'h0000_1111);
`endif
    idle();
    cycle();

    // Test 4: stall lane 2 for three cycles with a writeback during the stall.
    held_uop = 48'h0000_4444_4444;
    idle();
    issue(2, 6'd5, 6'd12, held_uop);
    cycle();
    idle();
    ex_ready = 4'b1011;
    issue(2, 6'd3, 6'd4, 48'h0000_5555_5555);
    for (int c = 0; c < 3; c++) begin
      wb_valid = '0;
      if (c == 1) set_wb(1, 6'd12, 32'h0000_0077);
      cycle();
      check("stall uop stable", 64'(ex_uop[2*UOP_W +: UOP_W]), 64'(held_uop));
      check("stall iss_ready", 64'(iss_ready[2]), 64'h0);
      check("stall ex_valid", 64'(ex_valid[2]), 64'h1);
    end
`ifdef RR_BYPASS_EN
    check("held operand updated", 64'(ex_src2_val[2*32 +: 32]), 64'h0000_0077);
`else
    check("held operand kept", 64'(ex_src2_val[2*32 +: 32]), 64'h0000_0003);
`endif
    idle();
    cycle();

    // Test 5: flush with all lanes valid and stalled, then normal accept.
    idle();
    for (int i = 0; i < NUM_FUS; i++) issue(i, 6'd5, 6'd7, 48'(32'h1000 + i));
    cycle();
    ex_ready = '0;
    flush_en = 1'b1;
    for (int i = 0; i < NUM_FUS; i++) issue(i, 6'd7, 6'd5, 48'(32'h2000 + i));
    cycle();
    check("flush clears valid", 64'(ex_valid), 64'h0);
    flush_en = 1'b0;
    ex_ready = '1;
    cycle();
    check("accept after flush", 64'(ex_valid), 64'hF);
    for (int i = 0; i < NUM_FUS; i++)
      check($sformatf("post-flush uop[%0d]", i), 64'(ex_uop[i*UOP_W +: UOP_W]), 64'(32'h2000 + i));
    idle();
    cycle();

    // Test 6: preg 0 reads as zero even while a writeback targets it.
    idle();
    issue(0, 6'd0, 6'd7, 48'h0000_0000_6666);
    set_wb(0, 6'd0, 32'h0000_FFFF);
    cycle();
    check("x0 operand", 64'(ex_src1_val[0 +: 32]), 64'h0);
    check("x0 other operand", 64'(ex_src2_val[0 +: 32]), 64'h0000_BEEF);
    idle();
    cycle();

    // Randomized traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      iss_valid = 4'($urandom);
      ex_ready  = 4'($urandom);
      flush_en  = ($urandom_range(0, 19) == 0);
      iss_uop   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < NUM_FUS; i++) begin
        iss_src1[i*PREG_W +: PREG_W] = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7));
        iss_src2[i*PREG_W +: PREG_W] = 6'($urandom_range(0, 7));
      end
      for (int j = 0; j < NUM_WB; j++) begin
        wb_valid[j] = ($urandom_range(0, 1) == 1);
        wb_dst[j*PREG_W +: PREG_W] = 6'($urandom_range(0, 7));
        wb_val[j*32 +: 32] = $urandom;
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
